// File: rtl/mux21_rr_sched_4b_pkg.sv
// Shared constants for the round-robin 2:1 mux scheduler: FSM encodings,
// default sizing and the FIFO pointer-width helper.
package mux21_sched_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HOLD0 = 2'd1;
    localparam logic [1:0] ST_HOLD1 = 2'd2;

    localparam int DEF_DATA_W     = 4;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_BURST_LEN  = 2;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    localparam int DEF_PTR_W = ptr_width(DEF_FIFO_DEPTH);

endpackage

// File: rtl/mux21_rr_sched_4b_if.sv
// Bundle of the two requester handshakes and the scheduled output handshake.
// The master side is the environment, the slave side is the scheduler.
interface mux21_rr_sched_4b_if
    import mux21_sched_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic [DATA_W-1:0] in0;
    logic              in0_valid;
    logic              in0_ready;
    logic [DATA_W-1:0] in1;
    logic              in1_valid;
    logic              in1_ready;
    logic [DATA_W-1:0] out;
    logic              out_valid;
    logic              out_ready;
    logic              out_sel;
    logic              busy;

    modport master (
        output in0, in0_valid, in1, in1_valid, out_ready,
        input  in0_ready, in1_ready, out, out_valid, out_sel, busy
    );

    modport slave (
        input  in0, in0_valid, in1, in1_valid, out_ready,
        output in0_ready, in1_ready, out, out_valid, out_sel, busy
    );
endinterface

// File: rtl/mux21_rr_sched_4b_fifo.sv
// Single-clock FIFO with async reset; pushes while full and pops while empty
// are ignored, so callers may drive raw valid/request signals.
module sync_fifo_4b
    import mux21_sched_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic              o_full,
    output logic              o_empty,
    output logic [DATA_W-1:0] o_head
);
    localparam int PTR_W = ptr_width(DEPTH);

    logic [PTR_W-1:0]  r_wrPtr;
    logic [PTR_W-1:0]  r_rdPtr;
    logic [PTR_W:0]    r_count;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_doPush;
    logic              w_doPop;

    assign o_full   = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_head   = r_mem[r_rdPtr];
    assign w_doPush = i_push && !o_full;
    assign w_doPop  = i_pop && !o_empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_doPush) r_mem[r_wrPtr] <= i_data;
    end

endmodule

// File: rtl/mux21_rr_sched_4b.sv
// Round-robin scheduler sharing one registered 2:1 mux between two FIFO-backed
// requesters, with a burst limit applied only while the other side waits.
module mux21_rr_sched_4b
    import mux21_sched_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int BURST_LEN  = DEF_BURST_LEN
) (
    input  logic                clk,
    input  logic                reset,
    mux21_rr_sched_4b_if.slave  bus
);
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST_LEN);

    logic              w_full0, w_empty0, w_full1, w_empty1;
    logic [DATA_W-1:0] w_head0, w_head1;
    logic              w_grant, w_load, w_pop0, w_pop1, w_match;
    logic [1:0]        r_state, w_nextState;
    logic [CNT_W-1:0]  r_cnt, w_nextCnt;
    logic              r_lastGrant, w_nextLast;
    logic [DATA_W-1:0] r_out;
    logic              r_outValid, r_outSel;
    logic              w_busy;

    sync_fifo_4b #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo0 (
        .clk(clk), .reset(reset), .i_push(bus.in0_valid), .i_data(bus.in0),
        .i_pop(w_pop0), .o_full(w_full0), .o_empty(w_empty0), .o_head(w_head0)
    );

    sync_fifo_4b #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo1 (
        .clk(clk), .reset(reset), .i_push(bus.in1_valid), .i_data(bus.in1),
        .i_pop(w_pop1), .o_full(w_full1), .o_empty(w_empty1), .o_head(w_head1)
    );

    assign bus.in0_ready = !w_full0;
    assign bus.in1_ready = !w_full1;

    // Holder keeps the grant until its burst is used up and the other side waits.
    always_comb begin
        w_grant = r_lastGrant;
        if (r_state == ST_HOLD0 && !w_empty0 && (r_cnt < BURST_MAX || w_empty1))
            w_grant = 1'b0;
        else if (r_state == ST_HOLD1 && !w_empty1 && (r_cnt < BURST_MAX || w_empty0))
            w_grant = 1'b1;
        else if (!w_empty0 && !w_empty1)
            w_grant = (r_state == ST_HOLD0) ? 1'b1 :
                      (r_state == ST_HOLD1) ? 1'b0 : !r_lastGrant;
        else if (!w_empty0)
            w_grant = 1'b0;
        else if (!w_empty1)
            w_grant = 1'b1;
    end

    assign w_load  = (!r_outValid || bus.out_ready) && (w_grant ? !w_empty1 : !w_empty0);
    assign w_pop0  = w_load && !w_grant;
    assign w_pop1  = w_load && w_grant;
    assign w_match = (r_state == ST_HOLD0 && !w_grant) || (r_state == ST_HOLD1 && w_grant);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_lastGrant <= 1'b1;
        end else begin
            r_state     <= w_nextState;
            r_cnt       <= w_nextCnt;
            r_lastGrant <= w_nextLast;
        end
    end

    // Backpressure with data pending leaves the FSM untouched.
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        w_nextLast  = r_lastGrant;
        if (w_load) begin
            w_nextState = w_grant ? ST_HOLD1 : ST_HOLD0;
            w_nextLast  = w_grant;
            if (!w_match)
                w_nextCnt = CNT_W'(1);
            else if (r_cnt < BURST_MAX)
                w_nextCnt = r_cnt + 1'b1;
        end else if (w_empty0 && w_empty1) begin
            w_nextState = ST_IDLE;
            w_nextCnt   = '0;
        end
    end

    always_comb begin
        w_busy = (r_state != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out      <= '0;
            r_outValid <= 1'b0;
            r_outSel   <= 1'b0;
        end else if (w_load) begin
            r_out      <= w_grant ? w_head1 : w_head0;
            r_outSel   <= w_grant;
            r_outValid <= 1'b1;
        end else if (r_outValid && bus.out_ready) begin
            r_outValid <= 1'b0;
        end
    end

    assign bus.out       = r_out;
    assign bus.out_valid = r_outValid;
    assign bus.out_sel   = r_outSel;
    assign bus.busy      = w_busy;

endmodule

// File: tb/tb_mux21_rr_sched_4b.sv
// Scoreboard bench: scenarios queue hand-computed words, a negedge monitor
// pops and compares on every accepted output handshake.
module tb_mux21_rr_sched_4b;
    import mux21_sched_pkg::*;

    typedef struct {
        logic [3:0] data;
        logic       sel;
    } exp_t;

    logic clk;
    logic reset;
    int   nCompared;
    int   nMismatched;
    exp_t expQ[$];

    mux21_rr_sched_4b_if #(.DATA_W(4)) intf ();

    mux21_rr_sched_4b #(.DATA_W(4), .FIFO_DEPTH(4), .BURST_LEN(2)) dut (
        .clk(clk),
        .reset(reset),
        .bus(intf.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void checkOutput(input string name, input logic [31:0] actual,
                                        input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, want %0h at %0t", name, actual, expected, $time);
        end
    endfunction

    function automatic void timeoutFail(input string name);
        nCompared++;
        nMismatched++;
        $display("[TB] FAIL %s: timed out at %0t", name, $time);
    endfunction

    function automatic void expectWord(input logic [3:0] data, input logic sel);
        exp_t e;
        e.data = data;
        e.sel  = sel;
        expQ.push_back(e);
    endfunction

    // Every accepted output word must be the next one the scenario predicted.
    always @(negedge clk) begin
        if (!reset && intf.out_valid && intf.out_ready) begin
            if (expQ.size() == 0) begin
                nCompared++;
                nMismatched++;
                $display("[TB] FAIL unexpected_out: got %0h sel %0b, want none", intf.out, intf.out_sel);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("out_data", 32'(intf.out), 32'(e.data));
                checkOutput("out_sel", 32'(intf.out_sel), 32'(e.sel));
            end
        end
    end

    task automatic applyStimulus(input logic v0, input logic [3:0] d0,
                                 input logic v1, input logic [3:0] d1);
        intf.in0_valid = v0;
        intf.in0       = d0;
        intf.in1_valid = v1;
        intf.in1       = d1;
        @(posedge clk);
        #1;
        intf.in0_valid = 1'b0;
        intf.in1_valid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic void checkResetValues(input string tag);
        checkOutput({tag, "_out_valid"}, 32'(intf.out_valid), 32'd0);
        checkOutput({tag, "_out"}, 32'(intf.out), 32'd0);
        checkOutput({tag, "_out_sel"}, 32'(intf.out_sel), 32'd0);
        checkOutput({tag, "_busy"}, 32'(intf.busy), 32'd0);
        checkOutput({tag, "_in0_ready"}, 32'(intf.in0_ready), 32'd1);
        checkOutput({tag, "_in1_ready"}, 32'(intf.in1_ready), 32'd1);
    endfunction

    // Pulses reset between edges; called one time unit after a posedge.
    task automatic doReset(input logic doCheck, input string tag);
        reset = 1'b1;
        expQ.delete();
        intf.in0_valid = 1'b0;
        intf.in1_valid = 1'b0;
        #1;
        if (doCheck) checkResetValues(tag);
        #1;
        reset = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            if (expQ.size() == 0 && !intf.out_valid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) timeoutFail(name);
    endtask

    task automatic pushOne0(input logic [3:0] data);
        bit accepted;
        accepted = 1'b0;
        intf.in0       = data;
        intf.in0_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            accepted = intf.in0_ready;
            @(posedge clk);
            #1;
            if (accepted) break;
        end
        intf.in0_valid = 1'b0;
        if (!accepted) timeoutFail("push_retry");
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        nCompared      = 0;
        nMismatched    = 0;
        reset          = 1'b1;
        intf.in0       = '0;
        intf.in0_valid = 1'b0;
        intf.in1       = '0;
        intf.in1_valid = 1'b0;
        intf.out_ready = 1'b0;

        #1;
        checkResetValues("por");
        @(posedge clk);
        #3;
        reset = 1'b0;

        // Load a word under backpressure, then reset must clear it without an edge.
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 4'h0, 1'b1, 4'hF);
        idleCycles(1);
        checkOutput("pre_rst_valid", 32'(intf.out_valid), 32'd1);
        checkOutput("pre_rst_out", 32'(intf.out), 32'hF);
        checkOutput("pre_rst_sel", 32'(intf.out_sel), 32'd1);
        checkOutput("pre_rst_busy", 32'(intf.busy), 32'd1);
        doReset(1'b1, "async_rst");

        // Single source with first-word latency and busy drop.
        intf.out_ready = 1'b1;
        expectWord(4'h3, 1'b0);
        expectWord(4'h5, 1'b0);
        expectWord(4'h9, 1'b0);
        applyStimulus(1'b1, 4'h3, 1'b0, 4'h0);
        checkOutput("lat_valid_n", 32'(intf.out_valid), 32'd0);
        applyStimulus(1'b1, 4'h5, 1'b0, 4'h0);
        checkOutput("lat_valid_n1", 32'(intf.out_valid), 32'd1);
        checkOutput("lat_out_n1", 32'(intf.out), 32'h3);
        applyStimulus(1'b1, 4'h9, 1'b0, 4'h0);
        idleCycles(1);
        checkOutput("busy_last", 32'(intf.busy), 32'd1);
        idleCycles(1);
        checkOutput("busy_drop", 32'(intf.busy), 32'd0);
        waitDrain("drain_single");

        // Backpressure fills FIFO0; word 6 has to be retried.
        intf.out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) expectWord(4'(i), 1'b0);
        for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 4'(i), 1'b0, 4'h0);
        checkOutput("bp_full_ready", 32'(intf.in0_ready), 32'd0);
        applyStimulus(1'b1, 4'h6, 1'b0, 4'h0);
        checkOutput("bp_hold_out", 32'(intf.out), 32'h1);
        checkOutput("bp_hold_valid", 32'(intf.out_valid), 32'd1);
        checkOutput("bp_still_full", 32'(intf.in0_ready), 32'd0);
        intf.out_ready = 1'b1;
        pushOne0(4'h6);
        waitDrain("drain_bp");

        // Round robin with a burst of two per source.
        doReset(1'b0, "");
        intf.out_ready = 1'b0;
        applyStimulus(1'b1, 4'h1, 1'b1, 4'hA);
        applyStimulus(1'b1, 4'h2, 1'b1, 4'hB);
        applyStimulus(1'b1, 4'h3, 1'b1, 4'hC);
        applyStimulus(1'b1, 4'h4, 1'b1, 4'hD);
        expectWord(4'h1, 1'b0);
        expectWord(4'h2, 1'b0);
        expectWord(4'hA, 1'b1);
        expectWord(4'hB, 1'b1);
        expectWord(4'h3, 1'b0);
        expectWord(4'h4, 1'b0);
        expectWord(4'hC, 1'b1);
        expectWord(4'hD, 1'b1);
        intf.out_ready = 1'b1;
        waitDrain("drain_rr");

        // Early handover from a one-word source without a bubble.
        doReset(1'b0, "");
        intf.out_ready = 1'b0;
        applyStimulus(1'b1, 4'h7, 1'b1, 4'h8);
        applyStimulus(1'b0, 4'h0, 1'b1, 4'h9);
        applyStimulus(1'b0, 4'h0, 1'b1, 4'hA);
        expectWord(4'h7, 1'b0);
        expectWord(4'h8, 1'b1);
        expectWord(4'h9, 1'b1);
        expectWord(4'hA, 1'b1);
        intf.out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            idleCycles(1);
            checkOutput("handover_no_bubble", 32'(intf.out_valid), 32'd1);
        end
        waitDrain("drain_handover");

        // Same traffic, reset after 7 and 8 have been accepted.
        doReset(1'b0, "");
        intf.out_ready = 1'b0;
        applyStimulus(1'b1, 4'h7, 1'b1, 4'h8);
        applyStimulus(1'b0, 4'h0, 1'b1, 4'h9);
        applyStimulus(1'b0, 4'h0, 1'b1, 4'hA);
        expectWord(4'h7, 1'b0);
        expectWord(4'h8, 1'b1);
        intf.out_ready = 1'b1;
        idleCycles(2);
        checkOutput("mid_rst_pending", 32'(expQ.size()), 32'd0);
        #1;
        doReset(1'b1, "mid_rst");
        idleCycles(1);
        checkOutput("post_rst_empty", 32'(intf.out_valid), 32'd0);
        expectWord(4'h1, 1'b0);
        expectWord(4'h2, 1'b1);
        applyStimulus(1'b1, 4'h1, 1'b1, 4'h2);
        waitDrain("drain_post_rst");

        idleCycles(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
